// File: rtl/shake_arbiter.sv
// shake_arbiter: round-robin session arbiter in front of a single SHAKE core.
// A client owns the core from grant until it drops its request; the core
// sponge is then wiped with a one-cycle clear pulse before the next grant.
module shake_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_IN_BITS  = 64,
    parameter int DATA_OUT_BITS = 64,
    parameter int LEN_W         = $clog2(DATA_IN_BITS) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              i_req,
    output logic [NUM_REQ-1:0]              o_grant,
    input  logic [NUM_REQ*DATA_IN_BITS-1:0] i_cl_data_in,
    input  logic [NUM_REQ-1:0]              i_cl_in_valid,
    input  logic [NUM_REQ-1:0]              i_cl_in_last,
    input  logic [NUM_REQ*LEN_W-1:0]        i_cl_last_len,
    output logic [NUM_REQ-1:0]              o_cl_in_ready,
    input  logic [NUM_REQ-1:0]              i_cl_out_ready,
    output logic [NUM_REQ-1:0]              o_cl_out_valid,
    output logic [DATA_OUT_BITS-1:0]        o_cl_data_out,
    output logic [DATA_IN_BITS-1:0]         o_core_data_in,
    output logic                            o_core_in_valid,
    output logic                            o_core_in_last,
    output logic [LEN_W-1:0]                o_core_last_len,
    output logic                            o_core_out_ready,
    input  logic                            i_core_in_ready,
    input  logic                            i_core_out_valid,
    input  logic [DATA_OUT_BITS-1:0]        i_core_data_out,
    output logic                            o_core_clear
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_next_grant;
    // While BUSY the pointer doubles as the index of the granted client.
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_next_ptr;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_cand;
    logic               w_busy;

    // Round-robin pick: first requester after the last winner, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_cand  = r_rr_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Next-state logic: grant on any request, release when the owner drops req.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_ptr   = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_BUSY;
                    w_next_grant = NUM_REQ'(1) << w_pick;
                    w_next_ptr   = w_pick;
                end
            end
            S_BUSY: begin
                if (!i_req[r_rr_ptr]) begin
                    w_next_state = S_CLEAR;
                    w_next_grant = '0;
                end
            end
            S_CLEAR: begin
                w_next_state = S_IDLE;
                w_next_grant = '0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_grant = '0;
            end
        endcase
    end

    // State, grant and priority pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state  <= w_next_state;
            r_grant  <= w_next_grant;
            r_rr_ptr <= w_next_ptr;
        end
    end

    assign w_busy        = (r_state == S_BUSY);
    assign o_grant       = r_grant;
    assign o_core_clear  = (r_state == S_CLEAR);
    assign o_cl_data_out = i_core_data_out;

    // Handshake mux: only the owning client sees the core; everything else is quiet.
    always_comb begin
        o_core_data_in   = '0;
        o_core_in_valid  = 1'b0;
        o_core_in_last   = 1'b0;
        o_core_last_len  = '0;
        o_core_out_ready = 1'b0;
        o_cl_in_ready    = '0;
        o_cl_out_valid   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_busy && (r_rr_ptr == IDX_W'(i))) begin
                o_core_data_in    = i_cl_data_in[i*DATA_IN_BITS +: DATA_IN_BITS];
                o_core_in_valid   = i_cl_in_valid[i];
                o_core_in_last    = i_cl_in_last[i];
                o_core_last_len   = i_cl_last_len[i*LEN_W +: LEN_W];
                o_core_out_ready  = i_cl_out_ready[i];
                o_cl_in_ready[i]  = i_core_in_ready;
                o_cl_out_valid[i] = i_core_out_valid;
            end
        end
    end

endmodule

// File: tb/tb_shake_arbiter.sv
// tb_shake_arbiter: directed phases on a randomized bus, every cycle checked
// against a session-level model of ownership, release and rotation.
module tb_shake_arbiter;
    localparam int N  = 4;
    localparam int DI = 64;
    localparam int DO = 64;
    localparam int LW = $clog2(DI) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [N*DI-1:0] cl_data_in;
    logic [N-1:0]    cl_in_valid, cl_in_last, cl_in_ready, cl_out_ready, cl_out_valid;
    logic [N*LW-1:0] cl_last_len;
    logic [DO-1:0]   cl_data_out;
    logic [DI-1:0]   core_data_in;
    logic            core_in_valid, core_in_last, core_out_ready, core_clear;
    logic [LW-1:0]   core_last_len;
    logic            core_in_ready, core_out_valid;
    logic [DO-1:0]   core_data_out;

    shake_arbiter #(.NUM_REQ(N), .DATA_IN_BITS(DI), .DATA_OUT_BITS(DO), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .i_req(req), .o_grant(grant),
        .i_cl_data_in(cl_data_in), .i_cl_in_valid(cl_in_valid), .i_cl_in_last(cl_in_last),
        .i_cl_last_len(cl_last_len), .o_cl_in_ready(cl_in_ready), .i_cl_out_ready(cl_out_ready),
        .o_cl_out_valid(cl_out_valid), .o_cl_data_out(cl_data_out),
        .o_core_data_in(core_data_in), .o_core_in_valid(core_in_valid), .o_core_in_last(core_in_last),
        .o_core_last_len(core_last_len), .o_core_out_ready(core_out_ready),
        .i_core_in_ready(core_in_ready), .i_core_out_valid(core_out_valid),
        .i_core_data_out(core_data_out), .o_core_clear(core_clear)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Session model: who owns the core, whether this is the wipe cycle, last winner.
    int m_owner = -1;
    bit m_clr   = 1'b0;
    int m_ptr   = N - 1;

    // Observation state shared with the directed phases.
    logic [N-1:0]  prev_grant = '0;
    int            zero_run   = 0;
    logic [N-1:0]  q_grants[$];
    int            q_gaps[$];
    logic [DI-1:0] q_core[$];
    logic          q_last[$];
    bit            rec_en  = 1'b0;
    bit            in_adv  = 1'b0;
    bit            out_adv = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit found;
        if (rst) begin
            m_owner = -1; m_clr = 1'b0; m_ptr = N - 1;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin m_owner = -1; m_clr = 1'b1; end
        end else if (m_clr) begin
            m_clr = 1'b0;
        end else begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && req[c]) begin found = 1'b1; m_owner = c; end
            end
            if (found) m_ptr = m_owner;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0]  e_grant, e_inr, e_ov;
        logic [DI-1:0] e_din;
        logic [LW-1:0] e_ll;
        logic          e_iv, e_il, e_or;
        e_grant = '0; e_inr = '0; e_ov = '0; e_din = '0; e_ll = '0;
        e_iv = 1'b0; e_il = 1'b0; e_or = 1'b0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_din            = cl_data_in[m_owner*DI +: DI];
            e_iv             = cl_in_valid[m_owner];
            e_il             = cl_in_last[m_owner];
            e_ll             = cl_last_len[m_owner*LW +: LW];
            e_or             = cl_out_ready[m_owner];
            e_inr[m_owner]   = core_in_ready;
            e_ov[m_owner]    = core_out_valid;
        end
        chk("grant", grant, e_grant);
        chk("core_clear", core_clear, m_clr);
        chk("core_data_in", core_data_in, e_din);
        chk("core_in_valid", core_in_valid, e_iv);
        chk("core_in_last", core_in_last, e_il);
        chk("core_last_len", core_last_len, e_ll);
        chk("core_out_ready", core_out_ready, e_or);
        chk("cl_in_ready", cl_in_ready, e_inr);
        chk("cl_out_valid", cl_out_valid, e_ov);
        chk("cl_data_out", cl_data_out, core_data_out);
    endtask

    // One clock: check at the falling edge, record events, advance the model.
    task automatic step();
        @(negedge clk);
        check_outputs();
        in_adv  = cl_in_ready[2] && cl_in_valid[2];
        out_adv = cl_out_valid[2] && cl_out_ready[2];
        if (rec_en && core_in_valid && core_in_ready) begin
            q_core.push_back(core_data_in);
            q_last.push_back(core_in_last);
        end
        if (grant != '0 && prev_grant == '0) begin
            q_grants.push_back(grant);
            q_gaps.push_back(zero_run);
        end
        zero_run   = (grant == '0) ? zero_run + 1 : 0;
        prev_grant = grant;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rnd_bus();
        for (int i = 0; i < N; i++) begin
            cl_data_in[i*DI +: DI]  = {$urandom, $urandom};
            cl_last_len[i*LW +: LW] = LW'($urandom);
        end
        cl_in_valid    = N'($urandom);
        cl_in_last     = N'($urandom);
        cl_out_ready   = N'($urandom);
        core_in_ready  = 1'($urandom);
        core_out_valid = 1'($urandom);
        core_data_out  = {$urandom, $urandom};
    endtask

    task automatic wait_grant(input string tag);
        int budget;
        budget = 20;
        while (grant == '0 && budget > 0) begin rnd_bus(); step(); budget--; end
        chk(tag, (grant != '0), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; rnd_bus(); step(); step();
        rst = 1'b0;
    endtask

    int word, sq, bp, budget, g;
    logic [N-1:0] exp_order [5];

    initial begin
        rst = 1'b1; req = '0; rnd_bus();
        @(posedge clk); model_edge(); #1;
        do_reset();

        // Single client: 8-word absorb with a 3-cycle stall, then 17 squeezes.
        req = 4'b0100; rec_en = 1'b1; word = 0; bp = 0; budget = 200;
        while (word < 8 && budget > 0) begin
            rnd_bus();
            cl_in_valid[2]          = 1'b1;
            cl_data_in[2*DI +: DI]  = 64'hA000 + 64'(word);
            cl_in_last[2]           = (word == 7);
            if (word == 4 && bp < 3) begin core_in_ready = 1'b0; bp++; end
            step();
            if (in_adv) word++;
            budget--;
        end
        rec_en = 1'b0;
        chk("absorb_words", word, 8);
        chk("absorb_core_beats", q_core.size(), 8);
        for (int i = 0; i < q_core.size() && i < 8; i++) begin
            chk("absorb_data", q_core[i], 64'hA000 + 64'(i));
            chk("absorb_last", q_last[i], (i == 7));
        end
        sq = 0; budget = 200;
        while (sq < 17 && budget > 0) begin
            rnd_bus(); cl_in_valid = '0; cl_out_ready[2] = 1'b1;
            step();
            if (out_adv) sq++;
            budget--;
        end
        chk("squeeze_words", sq, 17);
        req = '0; rnd_bus(); step(); step(); step();

        // Contention from reset: all four hold req, each session 5 cycles.
        do_reset();
        q_grants.delete(); q_gaps.delete();
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            wait_grant("contend_grant_wait");
            g = 0;
            for (int i = 0; i < N; i++) if (grant[i]) g = i;
            repeat (4) begin rnd_bus(); step(); end
            req[g] = 1'b0; rnd_bus(); step();
            req[g] = 1'b1;
        end
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        chk("contend_sessions", (q_grants.size() >= 5), 1'b1);
        for (int s = 0; s < 5 && s < q_grants.size(); s++) begin
            chk("contend_order", q_grants[s], exp_order[s]);
            if (s > 0) chk("contend_gap", q_gaps[s], 2);
        end
        req = '0; repeat (8) begin rnd_bus(); step(); end

        // Isolation: client 1 owns the core while the others wiggle everything.
        req = 4'b0010;
        wait_grant("iso_grant_wait");
        chk("iso_grant", grant, 4'b0010);
        repeat (30) begin rnd_bus(); step(); end
        req = '0; repeat (3) begin rnd_bus(); step(); end

        // Abort after 3 words, client 1 queued behind.
        req = 4'b0001;
        wait_grant("abort_grant_wait");
        repeat (3) begin rnd_bus(); cl_in_valid[0] = 1'b1; core_in_ready = 1'b1; step(); end
        req = 4'b0010; rnd_bus(); step();
        chk("abort_clear", core_clear, 1'b1);
        repeat (12) begin rnd_bus(); step(); end
        req = '0; repeat (3) begin rnd_bus(); step(); end

        // Reset in the middle of a squeeze.
        req = 4'b0100;
        wait_grant("rst_grant_wait");
        repeat (4) begin rnd_bus(); cl_out_ready[2] = 1'b1; step(); end
        req = 4'b1111; rst = 1'b1; rnd_bus(); step();
        chk("rst_grant", grant, '0);
        chk("rst_clear", core_clear, 1'b0);
        rst = 1'b0;
        q_grants.delete();
        wait_grant("post_rst_grant_wait");
        chk("post_rst_first", grant, 4'b0001);

        // Random soak: requests come and go, with occasional resets.
        req = '0;
        for (int c = 0; c < 500; c++) begin
            rnd_bus();
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shake_arbiter.md
# shake_arbiter

Round-robin arbiter that shares one SHAKE core (64-bit absorb/squeeze streaming interface) between up to NUM_REQ sampler clients such as SampleInBall, ExpandA, ExpandS and ExpandMask. Each client holds a session request for one full hash (absorb, then any number of squeeze blocks). The arbiter grants the core to exactly one client at a time and muxes the handshake signals. When the session is released, it clears the core's sponge state. It sits between the sampler blocks and the single SHAKE instance in the top-level key-gen/sign datapath.

## Interface
Parameters:
- NUM_REQ, 4, number of client ports (2..8)
- DATA_IN_BITS, 64, absorb word width
- DATA_OUT_BITS, 64, squeeze word width
- LEN_W, $clog2(DATA_IN_BITS)+1, width of last_len

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-client session request, level; held high for the whole session
- grant  out  NUM_REQ  one-hot registered grant; all-zero when no session is active
- cl_data_in  in  NUM_REQ*DATA_IN_BITS  client i occupies bits [i*DATA_IN_BITS +: DATA_IN_BITS]
- cl_in_valid  in  NUM_REQ  per-client absorb valid
- cl_in_last  in  NUM_REQ  per-client final absorb word flag
- cl_last_len  in  NUM_REQ*LEN_W  per-client valid bits in the final word
- cl_in_ready  out  NUM_REQ  per-client absorb ready
- cl_out_ready  in  NUM_REQ  per-client squeeze ready
- cl_out_valid  out  NUM_REQ  per-client squeeze valid
- cl_data_out  out  DATA_OUT_BITS  squeeze data broadcast to all clients
- core_data_in, core_in_valid, core_in_last, core_last_len, core_out_ready  out  SHAKE core inputs
- core_in_ready, core_out_valid  in  1 each  SHAKE core handshake
- core_data_out  in  DATA_OUT_BITS  SHAKE core squeeze data
- core_clear  out  1  one-cycle pulse that reinitialises the core sponge state

## Operation
- FSM states: IDLE, BUSY, CLEAR.
- Reset state: IDLE, grant=0, core_clear=0, rr_ptr=NUM_REQ-1, so client 0 has highest priority first.
- IDLE:
  - If req≠0, pick the first set bit scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Register that bit into grant, set rr_ptr to the chosen index, and go to BUSY.
- BUSY, with g the granted index. The core handshake is a combinational mux of client g:
  - core_data_in/in_valid/in_last/last_len/out_ready are driven from client g's signals.
  - cl_in_ready[g]=core_in_ready and cl_out_valid[g]=core_out_valid.
  - All other cl_in_ready/cl_out_valid bits are 0.
  - When req[g]=0, go to CLEAR. Requests from other clients are ignored until then.
- CLEAR:
  - core_clear=1 for exactly one cycle.
  - grant=0 and all core_* valid/ready outputs are 0.
  - Next state is IDLE.
- When grant=0 (IDLE, CLEAR, reset), all core_* outputs other than core_clear are 0, and all cl_in_ready/cl_out_valid bits are 0.
- cl_data_out=core_data_out unconditionally; clients qualify it with their own cl_out_valid.
- Arbitration is fair: a continuously requesting client waits at most NUM_REQ-1 sessions.

## Timing
- Grant latency: req rising in IDLE leads to grant high on the next edge. The datapath mux becomes active in the same cycle grant becomes visible.
- Handshakes pass through combinationally with zero added latency; a beat transfers when valid&&ready on the core side.
- Release: req[g] sampled low in BUSY gives:
  - cycle+1: CLEAR with core_clear=1 and grant=0;
  - cycle+2: IDLE;
  - cycle+3 earliest: next grant.
- Back-to-back sessions therefore have a 2-cycle gap.
- Boundary conditions:
  - A client that drops req mid-absorb or mid-squeeze still gets CLEAR. Partial state is discarded.
  - Beats presented by client g in the cycle req[g] falls are forwarded as normal. core_out_ready is 0 from CLEAR onward.
  - If req[g] is reasserted during CLEAR, it competes in the next IDLE at normal round-robin priority; g is now lowest priority.
  - If all NUM_REQ clients request simultaneously, the grant order is rr_ptr+1, rr_ptr+2, … in rotation.
  - rst asserted mid-session: next edge gives state IDLE, grant=0, rr_ptr=NUM_REQ-1, core_clear=0. The core is reset by the same rst.

## Test plan
- Single client: req[2]=1 from reset → grant=4'b0100 one cycle later. Absorb 8 words with cl_in_last on word 8 reaches the core unchanged. Squeeze 17 words to client 2 only. Dropping req → core_clear pulse, grant=0.
- Contention: req=4'b1111 held, each session 5 cycles → grant sequence 0001, 0010, 0100, 1000, 0001, with a 2-cycle gap between grants.
- Isolation: while client 1 is granted, client 3 toggles cl_in_valid/cl_out_ready → core inputs unaffected, cl_in_ready[3]=cl_out_valid[3]=0.
- Backpressure: core_in_ready low for 3 cycles mid-absorb → cl_in_ready[g] low for the same cycles and no beats are lost. Count 8 core-side transfers.
- Abort: client 0 drops req after 3 absorb words → CLEAR next cycle. A following client 1 session produces the reference SHAKE256 digest for its own seed.
- Reset mid-squeeze: rst high for one cycle during BUSY → grant=0 and core_clear=0 next cycle. req[0]=1 then grants client 0 first.
